// File: rtl/lsu_bus_bridge.sv
// -----------------------------------------------------------------------------
// lsu_bus_bridge
//
// Load/store stage sitting directly after the single-cycle datapath. Each
// RV32I load or store is turned into one word-wide bus transaction with byte
// enables. The handshake is request/acknowledge, and a timeout aborts the
// transaction if the acknowledge never comes. While the bus is busy, stall is
// raised so that the PC holds and the register write is suppressed.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   mem_rd     load request for the current instruction
//   mem_wr     store request (a store wins if mem_rd is also set)
//   funct3     access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr       byte address (ALUResult)
//   wdata      store data (WriteData), LSB-justified
//   rdata      extended load data to the result mux; valid in DONE
//   stall      combinational; holds the PC while an aligned access is pending
//   misalign   one-cycle pulse for a misaligned or undefined access
//   bus_err    one-cycle pulse (the DONE cycle) when the transaction timed out
//   bus_req    bus request, held until ack or timeout
//   bus_we     1 = write transaction
//   bus_addr   word-aligned address
//   bus_be     byte enables
//   bus_wdata  store data replicated into the byte lanes
//   bus_rdata  raw word returned by the bus
//   bus_ack    transaction complete; sampled only while in REQ
// -----------------------------------------------------------------------------
module lsu_bus_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_rd,
   input  logic              mem_wr,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              stall,
   output logic              misalign,
   output logic              bus_err,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [31:0]       bus_wdata,
   input  logic [31:0]       bus_rdata,
   input  logic              bus_ack
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] counter;
   logic [1:0]       off_q;      // byte offset of the access in flight
   logic [2:0]       f3_q;       // size/sign of the access in flight

   logic             req_any;
   logic             aligned;
   logic [3:0]       be_next;
   logic [31:0]      wdata_next;
   logic [31:0]      shifted;
   logic [31:0]      load_ext;

   assign req_any = mem_rd | mem_wr;

   // Size decode: alignment check, byte enables and lane replication.
   // An undefined funct3 is reported as misaligned so it never reaches the bus.
   always_comb begin
      aligned    = 1'b0;
      be_next    = '0;
      wdata_next = '0;
      case (funct3)
         3'b000, 3'b100: begin
            aligned    = 1'b1;
            be_next    = 4'b0001 << addr[1:0];
            wdata_next = {4{wdata[7:0]}};
         end
         3'b001, 3'b101: begin
            aligned    = ~addr[0];
            be_next    = 4'b0011 << addr[1:0];
            wdata_next = {2{wdata[15:0]}};
         end
         3'b010: begin
            aligned    = (addr[1:0] == 2'b00);
            be_next    = 4'b1111;
            wdata_next = wdata;
         end
         default: begin
            aligned    = 1'b0;
         end
      endcase
   end

   // DONE releases the stall so that the core commits on that edge.
   assign stall = req_any & aligned & (state != DONE);

   // Move the addressed byte/half down to bit 0, then extend it.
   assign shifted = bus_rdata >> {off_q, 3'b000};

   always_comb begin
      load_ext = shifted;
      case (f3_q)
         3'b000:  load_ext = {{24{shifted[7]}},  shifted[7:0]};
         3'b100:  load_ext = {24'h000000,        shifted[7:0]};
         3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
         3'b101:  load_ext = {16'h0000,          shifted[15:0]};
         default: load_ext = shifted;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         counter   <= '0;
         off_q     <= '0;
         f3_q      <= '0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_be    <= '0;
         bus_wdata <= '0;
         rdata     <= '0;
         misalign  <= 1'b0;
         bus_err   <= 1'b0;
      end else begin
         misalign <= 1'b0;
         bus_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (req_any && !aligned) begin
                  // Dropped access: no bus cycle, only the pulse and a zero result.
                  misalign <= 1'b1;
                  rdata    <= '0;
               end else if (req_any) begin
                  bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                  bus_we    <= mem_wr;
                  bus_be    <= be_next;
                  bus_wdata <= wdata_next;
                  off_q     <= addr[1:0];
                  f3_q      <= funct3;
                  bus_req   <= 1'b1;
                  counter   <= '0;
                  state     <= REQ;
               end
            end
            REQ: begin
               // The ack is checked first so that it wins over a timeout on the same cycle.
               if (bus_ack) begin
                  bus_req <= 1'b0;
                  rdata   <= bus_we ? '0 : load_ext;
                  state   <= DONE;
               end else if (counter == CNT_LAST) begin
                  bus_req <= 1'b0;
                  bus_err <= 1'b1;
                  rdata   <= '0;
                  state   <= DONE;
               end else begin
                  counter <= counter + 1'b1;
               end
            end
            DONE: begin
               counter <= '0;
               state   <= IDLE;
            end
            default: begin
               bus_req <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
module tb_lsu_bus_bridge;

   logic        clk;
   logic        reset;
   logic        mem_rd;
   logic        mem_wr;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        stall;
   logic        misalign;
   logic        bus_err;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;

   int checks = 0;
   int errors = 0;

   // Values observed by run_access.
   logic [31:0] o_rdata;
   logic        o_err;
   logic [31:0] o_addr;
   logic [3:0]  o_be;
   logic        o_we;
   logic [31:0] o_wdata;
   int          o_stall_cnt;
   int          o_req_cnt;

   lsu_bus_bridge #(
      .TIMEOUT_CYCLES(16),
      .ADDR_W(32)
   ) dut (
      .clk(clk),
      .reset(reset),
      .mem_rd(mem_rd),
      .mem_wr(mem_wr),
      .funct3(funct3),
      .addr(addr),
      .wdata(wdata),
      .rdata(rdata),
      .stall(stall),
      .misalign(misalign),
      .bus_err(bus_err),
      .bus_req(bus_req),
      .bus_we(bus_we),
      .bus_addr(bus_addr),
      .bus_be(bus_be),
      .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata),
      .bus_ack(bus_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Drives one aligned access starting in IDLE and follows it to DONE.
   // ack_delay = number of REQ cycles before ack (-1 = never ack).
   task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] brd, input int ack_delay);
      logic done;
      done        = 1'b0;
      o_stall_cnt = 0;
      o_req_cnt   = 0;
      o_rdata     = '0;
      o_err       = 1'b0;
      o_addr      = '0;
      o_be        = '0;
      o_we        = 1'b0;
      o_wdata     = '0;
      mem_rd      = rd;
      mem_wr      = wr;
      funct3      = f3;
      addr        = a;
      wdata       = wd;
      bus_rdata   = brd;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         bus_ack = 1'b0;
         #1;
         if (!stall) begin
            o_rdata = rdata;
            o_err   = bus_err;
            done    = 1'b1;
         end else begin
            o_stall_cnt++;
            if (bus_req) begin
               o_req_cnt++;
               o_addr  = bus_addr;
               o_be    = bus_be;
               o_we    = bus_we;
               o_wdata = bus_wdata;
               if (o_req_cnt - 1 == ack_delay) bus_ack = 1'b1;
            end
            @(posedge clk); #1;
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL access_complete: stall never dropped within 40 cycles (addr %h)", a);
      end
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      bus_ack = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      checks++;
      if ({bus_req, bus_we, bus_be, misalign, bus_err, stall} !== 9'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got req=%b we=%b be=%b mis=%b err=%b stall=%b expected all 0",
                  bus_req, bus_we, bus_be, misalign, bus_err, stall);
      end
      checks++;
      if ({bus_addr, bus_wdata, rdata} !== 96'b0) begin
         errors++;
         $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h expected 0", bus_addr, bus_wdata, rdata);
      end
   endtask

   task automatic test_lw;
      run_access(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);
      checks++;
      if (o_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_rdata: got %h expected %h", o_rdata, 32'hDEAD_BEEF); end
      checks++;
      if (o_addr !== 32'h0000_0100) begin errors++; $display("FAIL lw_addr: got %h expected %h", o_addr, 32'h100); end
      checks++;
      if (o_be !== 4'b1111 || o_we !== 1'b0) begin errors++; $display("FAIL lw_be_we: got be=%b we=%b expected 1111 0", o_be, o_we); end
      checks++;
      if (o_stall_cnt != 2 || o_req_cnt != 1) begin
         errors++; $display("FAIL lw_latency: got stall=%0d req=%0d expected 2 1", o_stall_cnt, o_req_cnt);
      end
      checks++;
      if (o_err !== 1'b0) begin errors++; $display("FAIL lw_err: got %b expected 0", o_err); end
      checks++;
      if (rdata !== 32'hDEAD_BEEF || bus_req !== 1'b0) begin
         errors++; $display("FAIL lw_hold: got rdata=%h req=%b expected deadbeef 0", rdata, bus_req);
      end
   endtask

   task automatic test_stores;
      run_access(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h5555_5555, 0);
      checks++;
      if (o_we !== 1'b1 || o_addr !== 32'h0000_0200 || o_be !== 4'b1100) begin
         errors++; $display("FAIL sh_ctrl: got we=%b addr=%h be=%b expected 1 00000200 1100", o_we, o_addr, o_be);
      end
      checks++;
      if (o_wdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata: got %h expected abcdabcd", o_wdata); end
      checks++;
      if (o_rdata !== 32'h0) begin errors++; $display("FAIL sh_rdata: got %h expected 0", o_rdata); end

      run_access(1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h1234_5677, 32'h0, 3);
      checks++;
      if (o_be !== 4'b0010 || o_addr !== 32'h0000_0100 || o_wdata !== 32'h7777_7777) begin
         errors++; $display("FAIL sb_lanes: got be=%b addr=%h wdata=%h expected 0010 00000100 77777777", o_be, o_addr, o_wdata);
      end
      checks++;
      if (o_req_cnt != 4 || o_stall_cnt != 5) begin
         errors++; $display("FAIL sb_wait: got req=%0d stall=%0d expected 4 5", o_req_cnt, o_stall_cnt);
      end

      run_access(1'b1, 1'b1, 3'b010, 32'h0000_0208, 32'h1122_3344, 32'h9999_9999, 0);
      checks++;
      if (o_we !== 1'b1 || o_be !== 4'b1111 || o_wdata !== 32'h1122_3344 || o_rdata !== 32'h0) begin
         errors++; $display("FAIL rdwr_is_write: got we=%b be=%b wdata=%h rdata=%h expected 1 1111 11223344 0",
                            o_we, o_be, o_wdata, o_rdata);
      end
   endtask

   task automatic test_subword_loads;
      run_access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h8011_2233, 0);
      checks++;
      if (o_be !== 4'b1000 || o_rdata !== 32'hFFFF_FF80) begin
         errors++; $display("FAIL lb: got be=%b rdata=%h expected 1000 ffffff80", o_be, o_rdata);
      end
      run_access(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h8011_2233, 0);
      checks++;
      if (o_rdata !== 32'h0000_0080) begin errors++; $display("FAIL lbu: got %h expected 00000080", o_rdata); end
      run_access(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h8011_2233, 0);
      checks++;
      if (o_be !== 4'b1100 || o_rdata !== 32'hFFFF_8011) begin
         errors++; $display("FAIL lh: got be=%b rdata=%h expected 1100 ffff8011", o_be, o_rdata);
      end
      run_access(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'h8011_2233, 0);
      checks++;
      if (o_rdata !== 32'h0000_8011) begin errors++; $display("FAIL lhu: got %h expected 00008011", o_rdata); end
   endtask

   task automatic test_misalign;
      mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h0000_0101;
      #1;
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL mis_stall: got %b expected 0", stall); end
      @(posedge clk); #1;
      checks++;
      if (misalign !== 1'b1 || bus_req !== 1'b0 || rdata !== 32'h0) begin
         errors++; $display("FAIL mis_pulse: got mis=%b req=%b rdata=%h expected 1 0 0", misalign, bus_req, rdata);
      end
      mem_rd = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (misalign !== 1'b0 || bus_req !== 1'b0) begin
         errors++; $display("FAIL mis_one_cycle: got mis=%b req=%b expected 0 0", misalign, bus_req);
      end

      mem_rd = 1'b1; funct3 = 3'b011; addr = 32'h0000_0100;
      @(posedge clk); #1;
      checks++;
      if (misalign !== 1'b1 || bus_req !== 1'b0) begin
         errors++; $display("FAIL undef_f3: got mis=%b req=%b expected 1 0", misalign, bus_req);
      end
      mem_rd = 1'b0;
      mem_wr = 1'b1; funct3 = 3'b010; addr = 32'h0000_0202;
      @(posedge clk); #1;
      checks++;
      if (misalign !== 1'b1 || bus_req !== 1'b0) begin
         errors++; $display("FAIL sw_misalign: got mis=%b req=%b expected 1 0", misalign, bus_req);
      end
      mem_wr = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_timeout;
      run_access(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h1234_5678, -1);
      checks++;
      if (o_req_cnt != 16 || o_stall_cnt != 17) begin
         errors++; $display("FAIL to_len: got req=%0d stall=%0d expected 16 17", o_req_cnt, o_stall_cnt);
      end
      checks++;
      if (o_err !== 1'b1 || o_rdata !== 32'h0) begin
         errors++; $display("FAIL to_err: got err=%b rdata=%h expected 1 0", o_err, o_rdata);
      end
      checks++;
      if (bus_err !== 1'b0 || bus_req !== 1'b0) begin
         errors++; $display("FAIL to_after: got err=%b req=%b expected 0 0", bus_err, bus_req);
      end
      // Ack on the last permitted cycle beats the timeout.
      run_access(1'b1, 1'b0, 3'b010, 32'h0000_0304, 32'h0, 32'hCAFE_F00D, 15);
      checks++;
      if (o_req_cnt != 16 || o_err !== 1'b0 || o_rdata !== 32'hCAFE_F00D) begin
         errors++; $display("FAIL to_ack_wins: got req=%0d err=%b rdata=%h expected 16 0 cafef00d",
                            o_req_cnt, o_err, o_rdata);
      end
   endtask

   task automatic test_reset_mid;
      mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h0000_0500; bus_rdata = 32'hAAAA_AAAA; bus_ack = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus_req !== 1'b1) begin errors++; $display("FAIL rm_in_req: got req=%b expected 1", bus_req); end
      reset = 1'b0;
      #1;
      checks++;
      if (bus_req !== 1'b0 || bus_addr !== 32'h0 || rdata !== 32'h0) begin
         errors++; $display("FAIL rm_async: got req=%b addr=%h rdata=%h expected 0 0 0", bus_req, bus_addr, rdata);
      end
      mem_rd = 1'b0; bus_ack = 1'b1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus_req !== 1'b0 || rdata !== 32'h0 || bus_err !== 1'b0) begin
         errors++; $display("FAIL rm_ack_ignored: got req=%b rdata=%h err=%b expected 0 0 0", bus_req, rdata, bus_err);
      end
      bus_ack = 1'b0;
      run_access(1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'h0, 32'h1357_9BDF, 0);
      checks++;
      if (o_rdata !== 32'h1357_9BDF || o_req_cnt != 1 || o_addr !== 32'h0000_0600) begin
         errors++; $display("FAIL rm_recover: got rdata=%h req=%0d addr=%h expected 13579bdf 1 00000600",
                            o_rdata, o_req_cnt, o_addr);
      end
   endtask

   task automatic test_back_to_back;
      run_access(1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0, 32'h0102_0304, 0);
      checks++;
      if (o_rdata !== 32'h0102_0304) begin errors++; $display("FAIL b2b_1: got %h expected 01020304", o_rdata); end
      run_access(1'b1, 1'b0, 3'b100, 32'h0000_0105, 32'h0, 32'hA0B0_C0D0, 1);
      checks++;
      if (o_rdata !== 32'h0000_00C0 || o_be !== 4'b0010) begin
         errors++; $display("FAIL b2b_2: got rdata=%h be=%b expected 000000c0 0010", o_rdata, o_be);
      end
      run_access(1'b1, 1'b0, 3'b001, 32'h0000_0106, 32'h0, 32'hFFFE_1234, 0);
      checks++;
      if (o_rdata !== 32'hFFFF_FFFE || o_be !== 4'b1100) begin
         errors++; $display("FAIL b2b_3: got rdata=%h be=%b expected fffffffe 1100", o_rdata, o_be);
      end
   endtask

   initial begin
      reset = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; funct3 = 3'b000;
      addr = '0; wdata = '0; bus_rdata = '0; bus_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset;
      reset = 1'b1;
      @(posedge clk); #1;
      test_reset;
      test_lw;
      test_stores;
      test_subword_loads;
      test_misalign;
      test_timeout;
      test_reset_mid;
      test_back_to_back;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_bus_bridge.md
Name: lsu_bus_bridge

Overview:
- Load/store stage directly downstream of the single-cycle datapath.
- Consumes ALUResult (address) and WriteData (store data) from the datapath, and returns ReadData to it.
- Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW accesses into word-wide bus transactions with byte enables.
- Uses a request/acknowledge handshake with timeout, and asserts a stall so the PC register holds while the bus is busy.

Parameters:
TIMEOUT_CYCLES, 16, maximum cycles waiting in REQ for bus_ack before aborting with an error.
ADDR_W, 32, width of the address input and bus_addr.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
mem_rd  input  1  load request for the current instruction.
mem_wr  input  1  store request for the current instruction.
funct3  input  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
addr  input  ADDR_W  byte address (ALUResult).
wdata  input  32  store data (WriteData), LSB-justified.
rdata  output  32  extended load data to the result mux (ReadData).
stall  output  1  hold PC and suppress register write while 1.
misalign  output  1  one-cycle pulse on a misaligned access.
bus_err  output  1  one-cycle pulse on a bus timeout.
bus_req  output  1  bus request, held until ack or timeout.
bus_we  output  1  1 = write transaction.
bus_addr  output  ADDR_W  word-aligned address (addr[1:0] forced to 00).
bus_be  output  4  byte enables.
bus_wdata  output  32  store data shifted into byte lanes.
bus_rdata  input  32  raw word returned by the bus.
bus_ack  input  1  transaction complete; sampled only in REQ.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; counter=0.
  - bus_req, bus_we, bus_be, bus_wdata, bus_addr, rdata, misalign, bus_err all 0.
  - Asserting reset mid-transaction drops bus_req immediately, with no completion.
- States: IDLE, REQ, DONE.
- stall is combinational:
  - 1 when (mem_rd|mem_wr) and aligned and state is IDLE or REQ.
  - 0 in DONE.
  - 0 for misaligned accesses.
- If mem_rd and mem_wr are both 1, the access is a write.
- Alignment rules:
  - H/HU require addr[0]=0; W requires addr[1:0]=00; bytes are always aligned.
  - Undefined funct3 (011, 110, 111) is treated as misaligned.
- IDLE, aligned request:
  - Register bus_addr, bus_we and bus_be.
  - Byte enables: B = 0001<<addr[1:0]; H = 0011<<addr[1:0]; W = 1111.
  - bus_wdata = wdata replicated into lanes (B: {4{wdata[7:0]}}, H: {2{wdata[15:0]}}, W: wdata).
  - Latch the byte offset and funct3; go to REQ.
- IDLE, misaligned request:
  - No bus transaction; state stays IDLE.
  - misalign=1 for exactly one cycle (registered) and rdata=0; the store is dropped.
  - The request must be deasserted by the core the next cycle (the PC advances), so misalign does not re-fire.
- REQ:
  - bus_req=1; counter increments each cycle.
  - On bus_ack: capture bus_rdata, go to DONE, bus_req=0 next cycle.
  - If the counter reaches TIMEOUT_CYCLES-1 without ack: go to DONE and set bus_err=1 for the DONE cycle, with rdata=0.
  - An ack arriving on the same cycle as the timeout wins (no error).
- DONE:
  - stall=0 and rdata valid for one cycle; the core commits on this edge.
  - Then unconditionally return to IDLE and clear the counter.
  - A new request is accepted only from IDLE, so back-to-back accesses cost one IDLE cycle each.
- Load extension (from the captured word, shifted right by 8×offset):
  - LB sign-extends bits [7:0].
  - LBU zero-extends bits [7:0].
  - LH sign-extends bits [15:0].
  - LHU zero-extends bits [15:0].
  - LW passes the word unchanged.
- rdata holds its value outside DONE; it is defined only in DONE for loads and is 0 for stores.
- bus_ack outside REQ is ignored.
- Latency: ack on the first REQ cycle gives a request-to-commit time of 3 cycles (IDLE, REQ, DONE), i.e. 2 stall cycles.

Test Plan:
- LW at addr=0x100, bus_rdata=0xDEADBEEF, ack on the first REQ cycle → bus_addr=0x100, be=1111, stall high for 2 cycles, rdata=0xDEADBEEF in DONE.
- LB at addr=0x103, bus_rdata=0x80112233 → be=1000, rdata=0xFFFFFF80; the same access as LBU → rdata=0x00000080.
- SH at addr=0x202, wdata=0x0000ABCD → bus_we=1, bus_addr=0x200, be=1100, bus_wdata=0xABCDABCD.
- LW at addr=0x101 → misalign=1 for one cycle, bus_req never asserted, stall=0.
- LW with no ack (TIMEOUT_CYCLES=16) → bus_req high for 16 cycles, then bus_err=1 and rdata=0 in DONE, then IDLE.
- Reset driven low during REQ with ack pending → bus_req=0 immediately and state=IDLE; a later ack is ignored; a new LW after reset release completes normally.
